// File: rtl/wb_pkg.sv
// Shared widths, buffer entry layout and grant encoding for the writeback port arbiter.
package wb_pkg;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned LU_DEPTH     = 2;
  localparam int unsigned STARVE_LIMIT = 3;
  localparam int unsigned CNT_W        = 2;
  localparam int unsigned STARVE_W     = 2;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_FIFO
  } grant_e;

  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
    return (cnt == STARVE_W'(STARVE_LIMIT)) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus between the pipeline/long-latency units and the register file write port.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic              pipe_valid;
  logic [REG_W-1:0]  pipe_reg;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic [REG_W-1:0]  lu_reg;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              stall_pipe;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  pipe_valid, pipe_reg, pipe_data, lu_valid, lu_reg, lu_data,
    output lu_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, fifo_count
  );

  modport master (
    output pipe_valid, pipe_reg, pipe_data, lu_valid, lu_reg, lu_data,
    input  lu_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, fifo_count
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry in-order buffer for long-latency results; slot0 is always the head.
module wb_fifo2
  import wb_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output wb_entry_t        head
);

  wb_entry_t slot0;
  wb_entry_t slot1;
  logic      do_push;
  logic      do_pop;

  assign do_push = push && (count != CNT_W'(LU_DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = slot0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count == '0) slot0 <= push_entry;
          else             slot1 <= push_entry;
          count <= count + 1'b1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 1'b1;
        end
        // Push is blocked when full, so a simultaneous push/pop only occurs with one entry.
        2'b11: slot0 <= push_entry;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the in-order pipeline and buffered long-latency results.
module wb_port_arbiter (
  input  logic               CLK,
  input  logic               RESET,
  wb_port_arbiter_if.slave   bus
);
  import wb_pkg::*;

  logic [CNT_W-1:0]    count;
  wb_entry_t           head;
  wb_entry_t           sel;
  grant_e              grant;
  logic [STARVE_W-1:0] starve;
  logic                stall;
  logic                push;
  logic                pop;
  logic                rf_we;
  logic [REG_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  assign bus.lu_ready   = (count != CNT_W'(LU_DEPTH));
  assign bus.fifo_count = count;
  assign bus.stall_pipe = stall;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;

  // The pipeline loses priority only once it has starved a non-empty buffer for the limit.
  assign stall = (starve == STARVE_W'(STARVE_LIMIT)) && (count != '0);
  assign push  = bus.lu_valid && bus.lu_ready;
  assign pop   = (grant == GRANT_FIFO);

  always_comb begin
    grant = GRANT_NONE;
    sel   = head;
    if (bus.pipe_valid && !stall) begin
      grant   = GRANT_PIPE;
      sel     = '{rd: bus.pipe_reg, data: bus.pipe_data};
    end else if (count != '0) begin
      grant = GRANT_FIFO;
    end
  end

  wb_fifo2 u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (push),
    .push_entry ('{rd: bus.lu_reg, data: bus.lu_data}),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      starve   <= '0;
    end else begin
      if (grant == GRANT_NONE) begin
        rf_we <= 1'b0;
      end else begin
        rf_we    <= (sel.rd != '0);
        rf_waddr <= sel.rd;
        rf_wdata <= sel.data;
      end
      starve <= (grant == GRANT_PIPE && count != '0) ? starve_inc(starve) : '0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios then randomized traffic against a queue-based model.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wb_entry_t   m_q[$];
  int unsigned m_starve;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic pv, input logic [4:0] preg, input logic [31:0] pdata,
                      input logic lv, input logic [4:0] lreg, input logic [31:0] ldata,
                      input logic r, output logic pipe_taken, output logic lu_taken);
    int unsigned sz;
    logic        exp_stall;
    wb_entry_t   e;
    @(negedge clk);
    bus.pipe_valid = pv;
    bus.pipe_reg   = preg;
    bus.pipe_data  = pdata;
    bus.lu_valid   = lv;
    bus.lu_reg     = lreg;
    bus.lu_data    = ldata;
    rst            = r;
    #1;
    sz        = m_q.size();
    exp_stall = (m_starve >= STARVE_LIMIT) && (sz > 0);
    check_eq("lu_ready",   32'(bus.lu_ready),   32'(sz < LU_DEPTH));
    check_eq("stall_pipe", 32'(bus.stall_pipe), 32'(exp_stall));
    check_eq("fifo_count", 32'(bus.fifo_count), sz);
    pipe_taken = 1'b0;
    lu_taken   = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      lu_taken = lv && (sz < LU_DEPTH);
      if (pv && !exp_stall) begin
        pipe_taken = 1'b1;
        m_we       = (preg != 5'd0);
        m_waddr    = preg;
        m_wdata    = pdata;
        m_starve   = (sz > 0) ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
      end else if (sz > 0) begin
        e        = m_q.pop_front();
        m_we     = (e.rd != 5'd0);
        m_waddr  = e.rd;
        m_wdata  = e.data;
        m_starve = 0;
      end else begin
        m_we     = 1'b0;
        m_starve = 0;
      end
      if (lu_taken) m_q.push_back('{rd: lreg, data: ldata});
    end
    @(posedge clk);
    #1;
    check_eq("rf_we", 32'(bus.rf_we), 32'(m_we));
    if (m_we) begin
      check_eq("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
      check_eq("rf_wdata", bus.rf_wdata, m_wdata);
    end
  endtask

  task automatic idle(input int unsigned n);
    logic pt, lt;
    repeat (n) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, pt, lt);
  endtask

  initial begin
    logic        pt, lt, pp, lp, rr;
    logic [4:0]  pr, lr;
    logic [31:0] pd, ld;
    int unsigned waited;

    rst            = 1'b1;
    bus.pipe_valid = 1'b0;
    bus.pipe_reg   = '0;
    bus.pipe_data  = '0;
    bus.lu_valid   = 1'b0;
    bus.lu_reg     = '0;
    bus.lu_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_rf_we",      32'(bus.rf_we), 32'd0);
    check_eq("rst_rf_waddr",   32'(bus.rf_waddr), 32'd0);
    check_eq("rst_rf_wdata",   bus.rf_wdata, 32'd0);
    check_eq("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    check_eq("rst_lu_ready",   32'(bus.lu_ready), 32'd1);
    check_eq("rst_stall",      32'(bus.stall_pipe), 32'd0);

    // Pipeline-only write, one cycle latency.
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, pt, lt);
    check_eq("pipe_we",    32'(bus.rf_we), 32'd1);
    check_eq("pipe_waddr", 32'(bus.rf_waddr), 32'd5);
    check_eq("pipe_wdata", bus.rf_wdata, 32'h1234);

    // Long-latency result through an idle port: enqueue, then write.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA, 1'b0, pt, lt);
    check_eq("lu_count1", 32'(bus.fifo_count), 32'd1);
    check_eq("lu_no_bypass", 32'(bus.rf_we), 32'd0);
    idle(1);
    check_eq("lu_we",    32'(bus.rf_we), 32'd1);
    check_eq("lu_waddr", 32'(bus.rf_waddr), 32'd7);
    check_eq("lu_wdata", bus.rf_wdata, 32'hAAAA);
    check_eq("lu_count0", 32'(bus.fifo_count), 32'd0);

    // Fill the buffer while the pipeline is busy; a third result must wait.
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA0, 1'b0, pt, lt);
    step(1'b1, 5'd2, 32'h22, 1'b1, 5'd11, 32'hB0, 1'b0, pt, lt);
    check_eq("full_lu_ready", 32'(bus.lu_ready), 32'd0);
    check_eq("full_count",    32'(bus.fifo_count), 32'd2);
    waited = 0;
    lt = 1'b0;
    while (!lt && waited < 10) begin
      step(1'b1, 5'(3 + waited), 32'h33 + waited, 1'b1, 5'd12, 32'hC0, 1'b0, pt, lt);
      waited++;
    end
    check_eq("full_third_accepted", 32'(lt), 32'd1);
    idle(4);

    // Starvation: three pipeline grants, then the buffer head wins.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, pt, lt);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b1, 5'(20 + i), 32'h200 + i, 1'b0, 5'd0, 32'd0, 1'b0, pt, lt);
      check_eq("starve_pipe_waddr", 32'(bus.rf_waddr), 20 + i);
    end
    step(1'b1, 5'd23, 32'h203, 1'b0, 5'd0, 32'd0, 1'b0, pt, lt);
    check_eq("starve_pipe_held", 32'(pt), 32'd0);
    check_eq("starve_fifo_waddr", 32'(bus.rf_waddr), 32'd9);
    check_eq("starve_fifo_wdata", bus.rf_wdata, 32'h99);
    step(1'b1, 5'd23, 32'h203, 1'b0, 5'd0, 32'd0, 1'b0, pt, lt);
    check_eq("starve_pipe_after", 32'(bus.rf_waddr), 32'd23);

    // Register 0 entry is consumed without a write.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, pt, lt);
    idle(1);
    check_eq("r0_we",    32'(bus.rf_we), 32'd0);
    check_eq("r0_count", 32'(bus.fifo_count), 32'd0);

    // Reset with a full buffer and a pipeline request.
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd13, 32'hD0, 1'b0, pt, lt);
    step(1'b1, 5'd5, 32'h55, 1'b1, 5'd14, 32'hE0, 1'b0, pt, lt);
    step(1'b1, 5'd6, 32'h66, 1'b1, 5'd15, 32'hF0, 1'b1, pt, lt);
    check_eq("mrst_we",       32'(bus.rf_we), 32'd0);
    check_eq("mrst_count",    32'(bus.fifo_count), 32'd0);
    check_eq("mrst_lu_ready", 32'(bus.lu_ready), 32'd1);
    check_eq("mrst_stall",    32'(bus.stall_pipe), 32'd0);

    // Randomized traffic; requests are held until accepted.
    pp = 1'b0;
    lp = 1'b0;
    pr = '0; pd = '0; lr = '0; ld = '0;
    repeat (3000) begin
      if (!pp && $urandom_range(0, 99) < 60) begin
        pp = 1'b1;
        pr = 5'($urandom_range(0, 31));
        pd = $urandom;
      end
      if (!lp && $urandom_range(0, 99) < 45) begin
        lp = 1'b1;
        lr = 5'($urandom_range(0, 31));
        ld = $urandom;
      end
      rr = ($urandom_range(0, 249) == 0);
      step(pp, pr, pd, lp, lr, ld, rr, pt, lt);
      if (pt || rr) pp = 1'b0;
      if (lt || rr) lp = 1'b0;
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL use one clock, CLK; reset RESET is synchronous and active-high.
REQ-002 SHALL expose these ports:
  CLK  in  1  clock
  RESET  in  1  synchronous active-high reset
  pipe_valid  in  1  in-order pipeline writeback request this cycle
  pipe_reg  in  5  pipeline destination register
  pipe_data  in  32  pipeline write data
  lu_valid  in  1  long-latency unit (mul/div/load-miss) result valid
  lu_reg  in  5  long-latency destination register
  lu_data  in  32  long-latency result data
  lu_ready  out  1  arbiter can accept lu result (FIFO not full)
  stall_pipe  out  1  pipeline must hold its WB request this cycle
  rf_we  out  1  register file write enable (registered)
  rf_waddr  out  5  register file write address (registered)
  rf_wdata  out  32  register file write data (registered)
  fifo_count  out  2  occupancy of lu buffer, 0..2

Function
REQ-003 SHALL arbitrate one register-file write port between the pipeline and a 2-entry in-order FIFO holding lu results.
REQ-004 SHALL enqueue lu result on a rising edge where lu_valid && lu_ready; lu_ready = (fifo_count != 2), combinational.
REQ-005 SHALL grant the pipeline when pipe_valid && !stall_pipe; otherwise SHALL grant the FIFO head when fifo_count != 0; otherwise no grant.
REQ-006 SHALL register the granted entry: grant in cycle N -> rf_we/rf_waddr/rf_wdata valid in cycle N+1 (1-cycle latency).
REQ-007 SHALL drive rf_we = 0 in cycle N+1 when nothing is granted in cycle N, or the granted register is 0; rf_waddr/rf_wdata hold previous values when nothing is granted.
REQ-008 SHALL still dequeue (consume) a granted FIFO entry targeting register 0.
REQ-009 SHALL keep a 2-bit starvation counter: increment (saturating at 3) each cycle the pipeline is granted while fifo_count != 0; clear on any FIFO grant or when fifo_count == 0.
REQ-010 SHALL assert stall_pipe combinationally when counter == 3 && fifo_count != 0; during that cycle pipe_valid is ignored and FIFO head is granted.
REQ-011 SHALL support simultaneous enqueue and dequeue in one cycle (count unchanged, entries shift in order).
REQ-012 SHALL when empty and lu_valid arrives, write it no earlier than 2 cycles later (enqueue edge, then grant); no bypass path.
REQ-013 SHALL never reorder FIFO entries; cross-source same-register ordering is the issue unit's responsibility.
REQ-014 SHALL not drop requests: a pipeline request is either granted or stall_pipe is high that cycle.

Reset
REQ-015 SHALL on RESET: rf_we=0, rf_waddr=0, rf_wdata=0, fifo_count=0, starvation counter=0, FIFO entries invalidated.
REQ-016 SHALL give RESET priority over enqueue/grant in the same cycle; in-flight lu results are discarded (lu_ready=1 after reset).
REQ-017 SHALL drive stall_pipe=0 and lu_ready=1 in the cycle following reset assertion.

Structure
REQ-018 SHALL place REG_W=5, DATA_W=32, LU_DEPTH=2, STARVE_LIMIT=3 in shared package wb_pkg.
REQ-019 SHALL implement the buffer as sub-module wb_fifo2 (push/pop/count/head); arbitration and counter in top.

Verification
REQ-020 Pipe only: pipe_valid=1, reg=5, data=0x1234 in cycle 0 -> rf_we=1, waddr=5, wdata=0x1234 in cycle 1.
REQ-021 LU idle path: lu_valid reg=7 data=0xAAAA cycle 0, pipe idle -> fifo_count=1 cycle 1, rf_we waddr=7 cycle 2, count=0.
REQ-022 Full FIFO: two lu pushes with pipe busy -> lu_ready=0, third lu_valid held until a dequeue; no data lost, order preserved.
REQ-023 Starvation: FIFO nonempty, pipe_valid continuous -> pipe granted 3 cycles, stall_pipe=1 on 4th, FIFO head written next cycle, counter cleared.
REQ-024 Reg 0: lu entry reg=0 granted -> rf_we=0, fifo_count decrements.
REQ-025 Reset mid-operation: RESET with count=2 and pipe_valid=1 -> next cycle rf_we=0, fifo_count=0, lu_ready=1, stall_pipe=0.
